// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/datapath bundle for the multicycle sequencer
// master = sequencer side, slave = datapath/memory side.
interface multicycle_controller_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [3:0]       opcode;
  logic             alu_zero;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_we;
  logic             pc_we;
  logic             pc_src;
  logic             reg_we;
  logic             mem_req;
  logic             mem_we;
  logic [2:0]       state;
  logic             halted;
  logic             illegal;
  logic             timeout;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    input  run, opcode, alu_zero, imem_ready, dmem_ready,
    output imem_req, ir_we, pc_we, pc_src, reg_we, mem_req, mem_we,
    output state, halted, illegal, timeout, retired_cnt
  );

  modport slave (
    output run, opcode, alu_zero, imem_ready, dmem_ready,
    input  imem_req, ir_we, pc_we, pc_src, reg_we, mem_req, mem_we,
    input  state, halted, illegal, timeout, retired_cnt
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit core
// Optional retired-instruction counter enabled by MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_controller #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_op;
  logic [7:0] r_wait;
  logic       r_illegal;
  logic       r_timeout;

  logic w_set_illegal, w_set_timeout, w_retire, w_wait_clr, w_wait_inc;
  logic w_imem_req, w_ir_we, w_pc_we, w_pc_src, w_reg_we, w_mem_req, w_mem_we;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_FETCH;
      r_op      <= 4'h0;
      r_wait    <= 8'd0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_op <= bus.opcode;
      if (w_wait_clr)
        r_wait <= 8'd0;
      else if (w_wait_inc)
        r_wait <= r_wait + 8'd1;
      if (w_set_illegal)
        r_illegal <= 1'b1;
      if (w_set_timeout)
        r_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;
    w_retire      = 1'b0;
    w_wait_clr    = 1'b0;
    w_wait_inc    = 1'b0;
    w_imem_req    = 1'b0;
    w_ir_we       = 1'b0;
    w_pc_we       = 1'b0;
    w_pc_src      = 1'b0;
    w_reg_we      = 1'b0;
    w_mem_req     = 1'b0;
    w_mem_we      = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_imem_req = bus.run;
        if (bus.run && bus.imem_ready) begin
          w_ir_we = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (bus.opcode >= 4'hC) begin
          w_next        = S_HALT;
          w_set_illegal = 1'b1;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_op == 4'h0 || r_op == 4'h1) begin
          w_next     = S_MEM;
          w_wait_clr = 1'b1;
        end else if (r_op == 4'hA || r_op == 4'hB) begin
          w_pc_we  = 1'b1;
          w_pc_src = (r_op == 4'hA) ? bus.alu_zero : ~bus.alu_zero;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (r_op == 4'h1);
        // A ready arriving on the limit cycle still completes normally.
        if (bus.dmem_ready) begin
          if (r_op == 4'h1) begin
            w_pc_we  = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (r_wait == LP_WAIT_LAST) begin
          w_next        = S_HALT;
          w_set_timeout = 1'b1;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_WB: begin
        w_reg_we = 1'b1;
        w_pc_we  = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
    if (i_reset) begin
      w_imem_req = 1'b0;
      w_ir_we    = 1'b0;
      w_pc_we    = 1'b0;
      w_pc_src   = 1'b0;
      w_reg_we   = 1'b0;
      w_mem_req  = 1'b0;
      w_mem_we   = 1'b0;
    end
  end

  assign bus.imem_req = w_imem_req;
  assign bus.ir_we    = w_ir_we;
  assign bus.pc_we    = w_pc_we;
  assign bus.pc_src   = w_pc_src;
  assign bus.reg_we   = w_reg_we;
  assign bus.mem_req  = w_mem_req;
  assign bus.mem_we   = w_mem_we;
  assign bus.state    = r_state;
  assign bus.halted   = (r_state == S_HALT);
  assign bus.illegal  = r_illegal;
  assign bus.timeout  = r_timeout;

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_cnt <= '0;
    else if (w_retire)
      r_cnt <= r_cnt + 1'b1;
  end

  assign bus.retired_cnt = r_cnt;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
  assign bus.retired_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed bench for multicycle_controller
module tb_multicycle_controller;

  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   retired;

  multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

  multicycle_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(15)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {imem_req, ir_we, pc_we, pc_src, reg_we, mem_req, mem_we}
  function automatic logic [6:0] strobes();
    return {bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_src, bus.reg_we, bus.mem_req, bus.mem_we};
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    return 32'(retired % (1 << CNT_W));
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Check state and strobes in the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [6:0] s);
    #1;
    chk({tag, "_state"}, 32'(bus.state), 32'(st));
    chk({tag, "_strobes"}, 32'(strobes()), 32'(s));
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    retired = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    retired = 0;
    reset = 1'b1;
    bus.run = 1'b0;
    bus.opcode = 4'h0;
    bus.alu_zero = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    tick();
    tick();
    bus.run = 1'b1;
    bus.imem_ready = 1'b1;
    #1;
    chk("rst_strobes", 32'(strobes()), 32'h0);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    chk("rst_cnt", 32'(bus.retired_cnt), 32'd0);
    tick();
    reset = 1'b0;

    // run=0 idles in FETCH with no request
    bus.run = 1'b0;
    cyc("idle", 3'd0, 7'h00);
    cyc("idle2", 3'd0, 7'h00);
    bus.run = 1'b1;

    // add: 4 cycles
    bus.opcode = 4'h2;
    cyc("add_f", 3'd0, 7'h60);
    cyc("add_d", 3'd1, 7'h00);
    cyc("add_e", 3'd2, 7'h00);
    cyc("add_wb", 3'd4, 7'h14);
    retired++;
    chk("add_cnt", 32'(bus.retired_cnt), exp_cnt());

    // lw with dmem_ready on the 4th MEM cycle: 8 cycles
    bus.opcode = 4'h0;
    bus.dmem_ready = 1'b0;
    cyc("lw_f", 3'd0, 7'h60);
    cyc("lw_d", 3'd1, 7'h00);
    cyc("lw_e", 3'd2, 7'h00);
    cyc("lw_m1", 3'd3, 7'h02);
    cyc("lw_m2", 3'd3, 7'h02);
    cyc("lw_m3", 3'd3, 7'h02);
    bus.dmem_ready = 1'b1;
    cyc("lw_m4", 3'd3, 7'h02);
    bus.dmem_ready = 1'b0;
    cyc("lw_wb", 3'd4, 7'h14);
    retired++;
    chk("lw_cnt", 32'(bus.retired_cnt), exp_cnt());

    // beqz taken, bneqz not taken, bneqz taken: 3 cycles each
    bus.opcode = 4'hA;
    bus.alu_zero = 1'b1;
    cyc("beqz_f", 3'd0, 7'h60);
    cyc("beqz_d", 3'd1, 7'h00);
    cyc("beqz_e", 3'd2, 7'h18);
    retired++;
    bus.opcode = 4'hB;
    cyc("bnez_f", 3'd0, 7'h60);
    cyc("bnez_d", 3'd1, 7'h00);
    cyc("bnez_e", 3'd2, 7'h10);
    retired++;
    bus.alu_zero = 1'b0;
    cyc("bnez0_f", 3'd0, 7'h60);
    cyc("bnez0_d", 3'd1, 7'h00);
    cyc("bnez0_e", 3'd2, 7'h18);
    retired++;
    chk("br_cnt", 32'(bus.retired_cnt), exp_cnt());

    // sw with zero-wait memory: 4 cycles
    bus.opcode = 4'h1;
    bus.dmem_ready = 1'b1;
    cyc("sw_f", 3'd0, 7'h60);
    cyc("sw_d", 3'd1, 7'h00);
    cyc("sw_e", 3'd2, 7'h00);
    cyc("sw_m", 3'd3, 7'h13);
    retired++;
    chk("sw_state", 32'(bus.state), 32'd0);
    chk("sw_cnt", 32'(bus.retired_cnt), exp_cnt());

    // sw timeout: 15 MEM cycles then HALT
    bus.dmem_ready = 1'b0;
    cyc("swto_f", 3'd0, 7'h60);
    cyc("swto_d", 3'd1, 7'h00);
    cyc("swto_e", 3'd2, 7'h00);
    for (int i = 0; i < 15; i++) cyc("swto_m", 3'd3, 7'h03);
    cyc("swto_halt", 3'd7, 7'h00);
    chk("swto_timeout", 32'(bus.timeout), 32'd1);
    chk("swto_halted", 32'(bus.halted), 32'd1);
    chk("swto_illegal", 32'(bus.illegal), 32'd0);
    chk("swto_cnt", 32'(bus.retired_cnt), exp_cnt());

    // sw with ready exactly on the 15th MEM cycle completes normally
    do_reset();
    chk("rst2_timeout", 32'(bus.timeout), 32'd0);
    cyc("swlim_f", 3'd0, 7'h60);
    cyc("swlim_d", 3'd1, 7'h00);
    cyc("swlim_e", 3'd2, 7'h00);
    for (int i = 0; i < 14; i++) cyc("swlim_m", 3'd3, 7'h03);
    bus.dmem_ready = 1'b1;
    cyc("swlim_m15", 3'd3, 7'h13);
    retired++;
    bus.dmem_ready = 1'b0;
    chk("swlim_state", 32'(bus.state), 32'd0);
    chk("swlim_timeout", 32'(bus.timeout), 32'd0);
    chk("swlim_cnt", 32'(bus.retired_cnt), exp_cnt());

    // illegal opcode halts; HALT ignores run for 20 cycles
    bus.opcode = 4'hE;
    cyc("ill_f", 3'd0, 7'h60);
    cyc("ill_d", 3'd1, 7'h00);
    for (int i = 0; i < 20; i++) cyc("ill_halt", 3'd7, 7'h00);
    chk("ill_illegal", 32'(bus.illegal), 32'd1);
    chk("ill_halted", 32'(bus.halted), 32'd1);
    chk("ill_cnt", 32'(bus.retired_cnt), exp_cnt());
    do_reset();
    chk("ill_rst_state", 32'(bus.state), 32'd0);
    chk("ill_rst_illegal", 32'(bus.illegal), 32'd0);
    chk("ill_rst_halted", 32'(bus.halted), 32'd0);

    // 16 back-to-back adds wrap a 4-bit counter
    bus.opcode = 4'h2;
    for (int i = 0; i < 16; i++) begin
      cyc("wrap_f", 3'd0, 7'h60);
      cyc("wrap_d", 3'd1, 7'h00);
      cyc("wrap_e", 3'd2, 7'h00);
      cyc("wrap_wb", 3'd4, 7'h14);
      retired++;
      if (i == 14) chk("wrap_cnt15", 32'(bus.retired_cnt), exp_cnt());
    end
    chk("wrap_cnt0", 32'(bus.retired_cnt), 32'd0);

    // reset asserted mid-MEM
    bus.opcode = 4'h0;
    cyc("rm_f", 3'd0, 7'h60);
    cyc("rm_d", 3'd1, 7'h00);
    cyc("rm_e", 3'd2, 7'h00);
    cyc("rm_m", 3'd3, 7'h02);
    reset = 1'b1;
    #1;
    chk("rm_gate", 32'(strobes()), 32'h0);
    tick();
    chk("rm_state", 32'(bus.state), 32'd0);
    chk("rm_mem_req", 32'(bus.mem_req), 32'd0);
    reset = 1'b0;
    retired = 0;
    cyc("rm_after", 3'd0, 7'h60);
    chk("rm_cnt", 32'(bus.retired_cnt), exp_cnt());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
